// File: rtl/alarm_pkg.sv
// Shared types and BCD digit limits for the alarm controller and its setpoint editor.
package alarm_pkg;

    typedef enum logic [1:0] {IDLE, SET, RING, SNOOZE} alarm_state_t;

    // Same cursor order the watch core uses for its display.
    typedef enum logic [1:0] {MINONE, MINDEC, HOURONE, HOURDEC} digit_sel_t;

    localparam logic [3:0] MINONE_MAX     = 4'd9;
    localparam logic [3:0] MINDEC_MAX     = 4'd5;
    localparam logic [3:0] HOURONE_MAX    = 4'd9;
    localparam logic [3:0] HOURONE_MAX_H2 = 4'd3;
    localparam logic [3:0] HOURDEC_MAX    = 4'd2;

    // Wrapping increment; >= keeps an out-of-range digit from running away.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/alarm_ctrl_bcd_setter.sv
// Alarm setpoint registers and digit cursor; applies increment/wrap/clamp rules
// on single-cycle inc/nxt pulses already gated by the controller FSM.
module bcd_alarm_setter #(
    parameter logic [3:0] INIT_HD = 4'd0,
    parameter logic [3:0] INIT_HO = 4'd7,
    parameter logic [3:0] INIT_MD = 4'd0,
    parameter logic [3:0] INIT_MO = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       home,
    input  logic       inc,
    input  logic       nxt,
    output logic [3:0] hourdec,
    output logic [3:0] hourone,
    output logic [3:0] mindec,
    output logic [3:0] minone,
    output logic [1:0] sel
);
    import alarm_pkg::*;

    logic [3:0] hd_n, ho_n, md_n, mo_n;
    logic [1:0] sel_n;
    digit_sel_t cur;

    assign cur = digit_sel_t'(sel);

    // Increment acts on the cursor as it stood before any same-cycle advance.
    always_comb begin
        hd_n  = hourdec;
        ho_n  = hourone;
        md_n  = mindec;
        mo_n  = minone;
        sel_n = sel;
        if (inc) begin
            unique case (cur)
                MINONE:  mo_n = bcd_inc(minone, MINONE_MAX);
                MINDEC:  md_n = bcd_inc(mindec, MINDEC_MAX);
                HOURONE: ho_n = bcd_inc(hourone,
                                        (hourdec == HOURDEC_MAX) ? HOURONE_MAX_H2 : HOURONE_MAX);
                HOURDEC: begin
                    hd_n = bcd_inc(hourdec, HOURDEC_MAX);
                    if (hd_n == HOURDEC_MAX && hourone > HOURONE_MAX_H2) begin
                        ho_n = HOURONE_MAX_H2;
                    end
                end
            endcase
        end
        if (home) begin
            sel_n = 2'd0;
        end else if (nxt) begin
            sel_n = sel + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hourdec <= INIT_HD;
            hourone <= INIT_HO;
            mindec  <= INIT_MD;
            minone  <= INIT_MO;
            sel     <= 2'd0;
        end else begin
            hourdec <= hd_n;
            hourone <= ho_n;
            mindec  <= md_n;
            minone  <= mo_n;
            sel     <= sel_n;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: compares watch time to the stored setpoint and runs the
// IDLE/SET/RING/SNOOZE sequence with ring timeout and snooze interval.
module alarm_ctrl #(
    parameter logic [3:0] INIT_HD    = 4'd0,
    parameter logic [3:0] INIT_HO    = 4'd7,
    parameter logic [3:0] INIT_MD    = 4'd0,
    parameter logic [3:0] INIT_MO    = 4'd0,
    parameter int         RING_SEC   = 60,
    parameter int         SNOOZE_SEC = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [3:0] hourdec_now,
    input  logic [3:0] hourone_now,
    input  logic [3:0] mindec_now,
    input  logic [3:0] minone_now,
    input  logic       alarm_en,
    input  logic       btn_set,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    output logic [3:0] hourdec_al,
    output logic [3:0] hourone_al,
    output logic [3:0] mindec_al,
    output logic [3:0] minone_al,
    output logic       set_mode,
    output logic [1:0] sel_digit,
    output logic       ring,
    output logic [1:0] state_dbg
);
    import alarm_pkg::*;

    localparam logic [7:0] RING_LIM = 8'(RING_SEC);
    localparam logic [9:0] SNZ_LIM  = 10'(SNOOZE_SEC);

    alarm_state_t state_q, state_n;
    logic [7:0]   ring_cnt_q, ring_cnt_n, ring_cnt_inc;
    logic [9:0]   snz_cnt_q, snz_cnt_n, snz_cnt_inc;
    logic [4:0]   btn_now, btn_q, btn_rise;
    logic         set_p, next_p, inc_p, stop_p, snooze_p;
    logic         match, match_d, match_rise;

    assign btn_now  = {btn_snooze, btn_stop, btn_inc, btn_next, btn_set};
    assign btn_rise = btn_now & ~btn_q;
    assign {snooze_p, stop_p, inc_p, next_p, set_p} = btn_rise;

    assign match = (hourdec_now == hourdec_al) && (hourone_now == hourone_al) &&
                   (mindec_now == mindec_al) && (minone_now == minone_al);
    assign match_rise = match & ~match_d;

    // Counters hold at their terminal value instead of wrapping.
    assign ring_cnt_inc = (sec_tick && ring_cnt_q < RING_LIM) ? ring_cnt_q + 8'd1 : ring_cnt_q;
    assign snz_cnt_inc  = (sec_tick && snz_cnt_q < SNZ_LIM) ? snz_cnt_q + 10'd1 : snz_cnt_q;

    always_comb begin
        state_n    = state_q;
        ring_cnt_n = ring_cnt_q;
        snz_cnt_n  = snz_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (set_p) begin
                    state_n = SET;
                end else if (match_rise && alarm_en) begin
                    state_n    = RING;
                    ring_cnt_n = '0;
                end
            end
            SET: begin
                if (set_p) state_n = IDLE;
            end
            RING: begin
                ring_cnt_n = ring_cnt_inc;
                if (stop_p) begin
                    state_n = IDLE;
                end else if (!alarm_en) begin
                    state_n = IDLE;
                end else if (snooze_p) begin
                    state_n   = SNOOZE;
                    snz_cnt_n = '0;
                end else if (ring_cnt_inc >= RING_LIM) begin
                    state_n = IDLE;
                end
            end
            SNOOZE: begin
                snz_cnt_n = snz_cnt_inc;
                if (stop_p || !alarm_en) begin
                    state_n = IDLE;
                end else if (snz_cnt_inc >= SNZ_LIM) begin
                    state_n    = RING;
                    ring_cnt_n = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            btn_q      <= '0;
            match_d    <= 1'b0;
            ring       <= 1'b0;
            set_mode   <= 1'b0;
        end else begin
            state_q    <= state_n;
            ring_cnt_q <= ring_cnt_n;
            snz_cnt_q  <= snz_cnt_n;
            btn_q      <= btn_now;
            match_d    <= match;
            ring       <= (state_n == RING);
            set_mode   <= (state_n == SET);
        end
    end

    assign state_dbg = state_q;

    // Editing pulses only reach the setpoint while in SET; entering SET homes the cursor.
    bcd_alarm_setter #(
        .INIT_HD(INIT_HD),
        .INIT_HO(INIT_HO),
        .INIT_MD(INIT_MD),
        .INIT_MO(INIT_MO)
    ) u_setter (
        .clk    (clk),
        .rst    (rst),
        .home   ((state_q == IDLE) && set_p),
        .inc    ((state_q == SET) && inc_p),
        .nxt    ((state_q == SET) && next_p),
        .hourdec(hourdec_al),
        .hourone(hourone_al),
        .mindec (mindec_al),
        .minone (minone_al),
        .sel    (sel_digit)
    );

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: setpoint editing against a digit model,
// ring/snooze/timeout sequencing, event priority and asynchronous reset.
module tb_alarm_ctrl;
  import alarm_pkg::*;

  localparam int RING_SEC   = 4;
  localparam int SNOOZE_SEC = 3;

  localparam logic [4:0] B_SET  = 5'b00001;
  localparam logic [4:0] B_NEXT = 5'b00010;
  localparam logic [4:0] B_INC  = 5'b00100;
  localparam logic [4:0] B_STOP = 5'b01000;
  localparam logic [4:0] B_SNZ  = 5'b10000;

  localparam int M_IDLE = 0, M_SET = 1, M_RING = 2, M_SNOOZE = 3;

  logic clk = 1'b0;
  logic rst, sec_tick, alarm_en;
  logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
  logic btn_set, btn_next, btn_inc, btn_stop, btn_snooze;
  logic [3:0] hourdec_al, hourone_al, mindec_al, minone_al;
  logic set_mode, ring;
  logic [1:0] sel_digit, state_dbg;

  int errors = 0;
  int checks = 0;

  // Reference model: digits indexed 0=minone 1=mindec 2=hourone 3=hourdec.
  int m_al[4];
  int m_sel;
  int m_mode;

  alarm_ctrl #(
    .INIT_HD(4'd0), .INIT_HO(4'd7), .INIT_MD(4'd0), .INIT_MO(4'd0),
    .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)
  ) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .hourdec_now(hourdec_now), .hourone_now(hourone_now),
    .mindec_now(mindec_now), .minone_now(minone_now),
    .alarm_en(alarm_en),
    .btn_set(btn_set), .btn_next(btn_next), .btn_inc(btn_inc),
    .btn_stop(btn_stop), .btn_snooze(btn_snooze),
    .hourdec_al(hourdec_al), .hourone_al(hourone_al),
    .mindec_al(mindec_al), .minone_al(minone_al),
    .set_mode(set_mode), .sel_digit(sel_digit), .ring(ring), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_al[0] = 0; m_al[1] = 0; m_al[2] = 7; m_al[3] = 0;
    m_sel = 0;
    m_mode = M_IDLE;
  endtask

  function automatic logic [15:0] model_al();
    return {4'(m_al[3]), 4'(m_al[2]), 4'(m_al[1]), 4'(m_al[0])};
  endfunction

  function automatic logic [15:0] dut_al();
    return {hourdec_al, hourone_al, mindec_al, minone_al};
  endfunction

  task automatic model_inc();
    case (m_sel)
      0: m_al[0] = (m_al[0] + 1) % 10;
      1: m_al[1] = (m_al[1] + 1) % 6;
      2: m_al[2] = (m_al[2] + 1) % ((m_al[3] == 2) ? 4 : 10);
      default: begin
        m_al[3] = (m_al[3] + 1) % 3;
        if (m_al[3] == 2 && m_al[2] > 3) m_al[2] = 3;
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic press(input logic [4:0] mask);
    bit was_set;
    {btn_snooze, btn_stop, btn_inc, btn_next, btn_set} = mask;
    step();
    {btn_snooze, btn_stop, btn_inc, btn_next, btn_set} = 5'b0;
    step();
    was_set = (m_mode == M_SET);
    if (was_set && mask[2]) model_inc();
    if (was_set && mask[1]) m_sel = (m_sel + 1) % 4;
    if (mask[0] && m_mode == M_IDLE) begin
      m_mode = M_SET;
      m_sel = 0;
    end else if (mask[0] && was_set) begin
      m_mode = M_IDLE;
    end
  endtask

  task automatic sec();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
    step();
  endtask

  task automatic set_now(input int hd, input int ho, input int md, input int mo);
    hourdec_now = 4'(hd);
    hourone_now = 4'(ho);
    mindec_now  = 4'(md);
    minone_now  = 4'(mo);
  endtask

  task automatic set_digit(input int idx, input int val);
    for (int k = 0; k < 4 && m_sel != idx; k++) press(B_NEXT);
    for (int k = 0; k < 10 && m_al[idx] != val; k++) press(B_INC);
  endtask

  task automatic retrigger();
    set_now(0, 7, 0, 1);
    step(); step();
    set_now(0, 7, 0, 0);
    step();
    m_mode = M_RING;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    sec_tick = 1'b0; alarm_en = 1'b0;
    {btn_snooze, btn_stop, btn_inc, btn_next, btn_set} = 5'b0;
    set_now(1, 2, 3, 4);
    model_reset();
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (dut_al() !== 16'h0700) begin errors++; $display("FAIL reset_digits: got %h want 0700", dut_al()); end
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL reset_ring: got %b want 0", ring); end
    checks++; if (set_mode !== 1'b0) begin errors++; $display("FAIL reset_set_mode: got %b want 0", set_mode); end
    checks++; if (sel_digit !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel_digit); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
  endtask

  task automatic test_set_digits();
    press(B_SET);
    checks++; if (set_mode !== 1'b1) begin errors++; $display("FAIL set_enter: got %b want 1", set_mode); end
    checks++; if (sel_digit !== 2'd0) begin errors++; $display("FAIL set_home: got %0d want 0", sel_digit); end
    for (int i = 0; i < 3; i++) press(B_INC);
    checks++; if (minone_al !== 4'd3) begin errors++; $display("FAIL minone_inc3: got %0d want 3", minone_al); end
    press(B_NEXT);
    for (int i = 0; i < 7; i++) press(B_INC);
    checks++; if (mindec_al !== 4'd1) begin errors++; $display("FAIL mindec_wrap: got %0d want 1", mindec_al); end
    checks++; if (dut_al() !== model_al()) begin errors++; $display("FAIL set_digits_model: got %h want %h", dut_al(), model_al()); end
    press(B_SET);
    checks++; if (set_mode !== 1'b0) begin errors++; $display("FAIL set_exit: got %b want 0", set_mode); end
  endtask

  task automatic test_hour_clamp();
    press(B_SET);
    set_digit(2, 8);
    set_digit(3, 1);
    checks++; if ({hourdec_al, hourone_al} !== 8'h18) begin errors++; $display("FAIL hour_18: got %h want 18", {hourdec_al, hourone_al}); end
    press(B_INC);
    checks++; if ({hourdec_al, hourone_al} !== 8'h23) begin errors++; $display("FAIL hour_clamp: got %h want 23", {hourdec_al, hourone_al}); end
    for (int k = 0; k < 4 && m_sel != 2; k++) press(B_NEXT);
    press(B_INC);
    checks++; if (hourone_al !== 4'd0) begin errors++; $display("FAIL hourone_wrap3: got %0d want 0", hourone_al); end
    checks++; if (dut_al() !== model_al()) begin errors++; $display("FAIL hour_model: got %h want %h", dut_al(), model_al()); end
    press(B_SET);
  endtask

  task automatic test_random_set();
    int r;
    logic [4:0] mask;
    press(B_SET);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      mask = (r == 1) ? B_NEXT : (r == 2) ? (B_INC | B_NEXT) : B_INC;
      press(mask);
      checks++; if (dut_al() !== model_al()) begin errors++; $display("FAIL rand_digits[%0d]: got %h want %h", i, dut_al(), model_al()); end
      checks++; if (sel_digit !== 2'(m_sel)) begin errors++; $display("FAIL rand_sel[%0d]: got %0d want %0d", i, sel_digit, m_sel); end
    end
    set_digit(3, 0);
    set_digit(2, 7);
    set_digit(1, 0);
    set_digit(0, 0);
    checks++; if (dut_al() !== 16'h0700) begin errors++; $display("FAIL restore_0700: got %h want 0700", dut_al()); end
    press(B_SET);
    checks++; if (set_mode !== 1'b0) begin errors++; $display("FAIL rand_exit: got %b want 0", set_mode); end
  endtask

  task automatic test_ring_timeout();
    alarm_en = 1'b1;
    set_now(0, 6, 5, 9);
    step(); step();
    set_now(0, 7, 0, 0);
    #1;
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL ring_latency_early: got %b want 0", ring); end
    step();
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_on: got %b want 1", ring); end
    checks++; if (state_dbg !== RING) begin errors++; $display("FAIL ring_state: got %0d want %0d", state_dbg, RING); end
    for (int i = 0; i < RING_SEC - 1; i++) sec();
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_before_timeout: got %b want 1", ring); end
    sec();
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL ring_timeout: got %b want 0", ring); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL timeout_state: got %0d want %0d", state_dbg, IDLE); end
    m_mode = M_IDLE;
    for (int i = 0; i < 5; i++) step();
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL no_rering: got %b want 0", ring); end
  endtask

  task automatic test_snooze();
    retrigger();
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL snz_ring_on: got %b want 1", ring); end
    press(B_SNZ);
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL snz_quiet: got %b want 0", ring); end
    checks++; if (state_dbg !== SNOOZE) begin errors++; $display("FAIL snz_state: got %0d want %0d", state_dbg, SNOOZE); end
    for (int i = 0; i < SNOOZE_SEC - 1; i++) sec();
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL snz_early: got %b want 0", ring); end
    sec();
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL snz_rering: got %b want 1", ring); end
    for (int i = 0; i < RING_SEC - 1; i++) sec();
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL snz_ringcnt_clear: got %b want 1", ring); end
    press(B_STOP);
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL stop_ring: got %b want 0", ring); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL stop_state: got %0d want %0d", state_dbg, IDLE); end
    m_mode = M_IDLE;
  endtask

  task automatic test_back_to_back();
    retrigger();
    press(B_SET);
    checks++; if (state_dbg !== RING || set_mode !== 1'b0) begin errors++; $display("FAIL set_in_ring: got state %0d set_mode %b want %0d/0", state_dbg, set_mode, RING); end
    press(B_STOP | B_SNZ);
    checks++; if (state_dbg !== IDLE || ring !== 1'b0) begin errors++; $display("FAIL stop_over_snz: got state %0d ring %b want %0d/0", state_dbg, ring, IDLE); end
    m_mode = M_IDLE;
    retrigger();
    alarm_en = 1'b0;
    step(); step();
    checks++; if (state_dbg !== IDLE || ring !== 1'b0) begin errors++; $display("FAIL en_low_ring: got state %0d ring %b want %0d/0", state_dbg, ring, IDLE); end
    alarm_en = 1'b1;
    retrigger();
    press(B_SNZ);
    alarm_en = 1'b0;
    step(); step();
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL en_low_snooze: got %0d want %0d", state_dbg, IDLE); end
    alarm_en = 1'b1;
    m_mode = M_IDLE;
    set_now(0, 7, 0, 1);
    step(); step();
    press(B_SET);
    set_now(0, 7, 0, 0);
    step(); step(); step();
    checks++; if (ring !== 1'b0 || state_dbg !== SET) begin errors++; $display("FAIL match_in_set: got ring %b state %0d want 0/%0d", ring, state_dbg, SET); end
    press(B_SET);
    step(); step(); step();
    checks++; if (ring !== 1'b0 || state_dbg !== IDLE) begin errors++; $display("FAIL no_ring_after_set: got ring %b state %0d want 0/%0d", ring, state_dbg, IDLE); end
  endtask

  task automatic test_reset_mid_ring();
    press(B_SET);
    set_digit(0, 5);
    press(B_SET);
    set_now(0, 7, 0, 4);
    step(); step();
    set_now(0, 7, 0, 5);
    step();
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL rst_pre_ring: got %b want 1", ring); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL rst_async_ring: got %b want 0", ring); end
    checks++; if (dut_al() !== 16'h0700) begin errors++; $display("FAIL rst_async_digits: got %h want 0700", dut_al()); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rst_async_state: got %0d want %0d", state_dbg, IDLE); end
    step();
    rst = 1'b0;
    model_reset();
    step(); step();
    checks++; if (ring !== 1'b0 || dut_al() !== model_al()) begin errors++; $display("FAIL rst_release: got ring %b al %h want 0/%h", ring, dut_al(), model_al()); end
  endtask

  initial begin
    test_reset();
    test_set_digits();
    test_hour_clamp();
    test_random_set();
    test_ring_timeout();
    test_snooze();
    test_back_to_back();
    test_reset_mid_ring();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
